ysyx_22050243_clint: RTL and testbench
======================================

# ysyx_22050243_clint

Core-local interruptor on the CPU data bus, a peer of the data memory: it decodes the core's data-port requests in the CLINT window and holds `msip`, `mtime` and `mtimecmp`. It drives the core's `i_clint_timer_irq` input and consumes its `timer_irq_ready_o` acknowledge. A one-shot handshake stops a served timer interrupt from re-firing until software rewrites `mtimecmp`.

## Interface
- `BASE_ADDR`, 64'h0000_0000_0200_0000, CLINT window base; window size is 64 KiB.
- `TICK_DIV`, 2, clock cycles per `mtime` increment; must be ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `data_r_en_i` in 1: read request.
- `data_w_en_i` in 1: write request.
- `data_wmask_i` in 8: byte-lane write enables.
- `data_addr_i` in 64: byte address.
- `data_w_i` in 64: write data.
- `data_r_o` out 64: read data.
- `data_r_valid_o` out 1: read response, one-cycle pulse.
- `data_w_ready_o` out 1: write done, one-cycle pulse.
- `hit_o` out 1: combinational; high when `data_addr_i` is in the window and an enable is high. Upstream uses it to steer the bus away from memory.
- `clint_timer_irq_o` out 1: machine timer interrupt request.
- `timer_irq_ready_i` in 1: core has taken the timer trap.
- `clint_soft_irq_o` out 1: equals `msip[0]`.

## Operation
- Register map, all 64-bit, aligned; offsets from `BASE_ADDR`:
  - `msip` at 0x0000; only bit 0 is implemented, other bits read as 0.
  - `mtimecmp` at 0x4000.
  - `mtime` at 0xBFF8.
  - Any other offset in the window reads 0 and ignores writes, but still gets a response.
- Address bits [2:0] are ignored; access is always 64-bit. Sub-word writes use `data_wmask_i`: byte k is written iff mask bit k is set.
- Request handling:
  - A request is accepted each cycle `hit_o` is high, so back-to-back requests are allowed.
  - Requests outside the window are ignored entirely and get no response.
  - If read and write are both asserted, the write takes priority; only `data_w_ready_o` pulses.
- `mtime` prescaler: `div_cnt` counts 0..TICK_DIV-1. `mtime` increments by 1 (mod 2^64) in the cycle `div_cnt == TICK_DIV-1`, and `div_cnt` returns to 0.
- A bus write to `mtime` overrides a same-cycle increment. The written value appears next cycle; `div_cnt` is not reset.
- `cmp = (mtime >= mtimecmp)`, 64-bit unsigned, computed from current register values.
- Timer FSM, state register `tstate`:
  - ARMED → FIRED when `cmp`.
  - FIRED → SERVED when `timer_irq_ready_i`.
  - FIRED → ARMED when a `mtimecmp` write makes `cmp` false.
  - SERVED → ARMED on any `mtimecmp` write, including partial-mask writes.
  - `clint_timer_irq_o` is registered: 1 exactly while `tstate == FIRED`.
  - `timer_irq_ready_i` is ignored outside FIRED.
  - A `mtimecmp` write in the same cycle as `ready` resolves to ARMED; the write wins.

## Timing
- Reset values:
  - `mtime` = 0, `div_cnt` = 0, `msip` = 0.
  - `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF.
  - `tstate` = ARMED.
  - All outputs = 0, except `hit_o`, which is combinational.
- Read latency is 1 cycle. `data_r_o` carries the register value sampled at the accept edge, before any same-cycle increment or write.
- `data_r_o` holds its value between responses.
- Write latency is 1 cycle: the register is updated at the accept edge and `data_w_ready_o` pulses the next cycle.
- Interrupt latency is 1 cycle: if `cmp` is true at edge N while ARMED, `clint_timer_irq_o` is high from cycle N+1. After `mtime` crosses `mtimecmp`, the IRQ rises within 1 cycle plus the prescale period.
- `rst` mid-transaction drops pending responses: no valid or ready pulse follows a reset cycle.

## Structure
- Shared package `ysyx_22050243_defs` holds:
  - `CLINT_MSIP_OFF`, `CLINT_MTIMECMP_OFF`, `CLINT_MTIME_OFF`.
  - The timer-state enum ARMED/FIRED/SERVED.
  - A byte-mask merge function.
- One sub-module, `ysyx_22050243_clint_timer`: holds the prescaler, `mtime`, `mtimecmp`, compare logic and timer FSM. The top level does decode, `msip` and bus response.

## Test plan
- Reset, then read `mtimecmp`: `data_r_valid_o` pulses 1 cycle later with 64'hFFFF_FFFF_FFFF_FFFF; `clint_timer_irq_o` = 0.
- TICK_DIV=2; read `mtime` 20 cycles after reset release: returns 10 (±1 for sample alignment); next read 4 cycles later returns +2.
- Write `mtimecmp`=16 with mask 8'hFF:
  - IRQ rises 1 cycle after `mtime` reaches 16.
  - Assert `ready` for 1 cycle: IRQ falls next cycle and stays low through `mtime` = 40.
  - Write `mtimecmp`=16 again: IRQ returns next cycle.
- Write `mtime` with mask 8'h0F and data 64'h1122_3344_5566_7788 while `mtime`=5: read returns 64'h0000_0000_5566_7788 plus any ticks since; `data_w_ready_o` pulses once.
- Address `BASE_ADDR`+0x8000 read: returns 0 with valid. Address `BASE_ADDR`+0x10000: `hit_o` = 0, no response.
- Simultaneous r_en/w_en to `msip` with data 1:
  - Only `data_w_ready_o` pulses.
  - `clint_soft_irq_o` = 1 next cycle.
  - Assert `rst` in the same cycle as a read: no valid pulse follows.

Source files
------------

// File: rtl/ysyx_22050243_clint_pkg.sv
// Shared CLINT definitions: register offsets, timer state encoding and
// the byte-lane merge used by every writable register.
package ysyx_22050243_defs;

   localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
   localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
   localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

   typedef enum logic [1:0] {
      ARMED  = 2'd0,
      FIRED  = 2'd1,
      SERVED = 2'd2
   } tstate_t;

   // Replace byte k of old_val with byte k of new_val wherever mask[k] is set.
   function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                               input logic [63:0] new_val,
                                               input logic [7:0]  mask);
      logic [63:0] res;
      res = old_val;
      for (int k = 0; k < 8; k++) begin
         if (mask[k]) res[8*k +: 8] = new_val[8*k +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/ysyx_22050243_clint_if.sv
// Core data-port bus as seen by the CLINT; the core side is the master.
interface ysyx_22050243_clint_if;
   logic        data_r_en_i;
   logic        data_w_en_i;
   logic [7:0]  data_wmask_i;
   logic [63:0] data_addr_i;
   logic [63:0] data_w_i;
   logic [63:0] data_r_o;
   logic        data_r_valid_o;
   logic        data_w_ready_o;
   logic        hit_o;

   modport master (
      output data_r_en_i, data_w_en_i, data_wmask_i, data_addr_i, data_w_i,
      input  data_r_o, data_r_valid_o, data_w_ready_o, hit_o
   );

   modport slave (
      input  data_r_en_i, data_w_en_i, data_wmask_i, data_addr_i, data_w_i,
      output data_r_o, data_r_valid_o, data_w_ready_o, hit_o
   );
endinterface

// File: rtl/ysyx_22050243_clint_timer.sv
// Machine timer: prescaler, mtime, mtimecmp, compare and the one-shot
// interrupt FSM that keeps a served interrupt quiet until mtimecmp changes.
import ysyx_22050243_defs::*;

module ysyx_22050243_clint_timer #(
   parameter int TICK_DIV = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mtime_we,
   input  logic        mtimecmp_we,
   input  logic [7:0]  wmask,
   input  logic [63:0] wdata,
   input  logic        irq_ready,
   output logic [63:0] mtime,
   output logic [63:0] mtimecmp,
   output logic        irq
);

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [DIV_W-1:0] div_cnt_reg;
   logic [63:0]      mtime_reg;
   logic [63:0]      mtimecmp_reg;
   logic [63:0]      mtimecmp_wval;
   logic             tick;
   logic             cmp;
   logic             cmp_after_wr;
   tstate_t          tstate_reg;
   tstate_t          tstate_next;

   assign tick          = (div_cnt_reg == DIV_W'(TICK_DIV - 1));
   assign mtimecmp_wval = merge_bytes(mtimecmp_reg, wdata, wmask);
   assign cmp           = (mtime_reg >= mtimecmp_reg);
   // Compare as it will look once the pending mtimecmp write lands.
   assign cmp_after_wr  = (mtime_reg >= mtimecmp_wval);

   // Prescaler and mtime; a bus write to mtime beats the same-cycle tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_reg <= '0;
         mtime_reg   <= '0;
      end else begin
         div_cnt_reg <= tick ? '0 : div_cnt_reg + 1'b1;
         if (mtime_we)  mtime_reg <= merge_bytes(mtime_reg, wdata, wmask);
         else if (tick) mtime_reg <= mtime_reg + 64'd1;
      end
   end

   // mtimecmp register, all-ones at reset so nothing fires before software arms it.
   always_ff @(posedge clk) begin
      if (rst) mtimecmp_reg <= '1;
      else if (mtimecmp_we) mtimecmp_reg <= mtimecmp_wval;
   end

   // Timer state register.
   always_ff @(posedge clk) begin
      if (rst) tstate_reg <= ARMED;
      else     tstate_reg <= tstate_next;
   end

   // Timer next-state: a mtimecmp write always outranks the acknowledge.
   always_comb begin
      tstate_next = tstate_reg;
      unique case (tstate_reg)
         ARMED: begin
            if (cmp) tstate_next = FIRED;
         end
         FIRED: begin
            if (mtimecmp_we) begin
               if (irq_ready || !cmp_after_wr) tstate_next = ARMED;
            end else if (irq_ready) begin
               tstate_next = SERVED;
            end
         end
         SERVED: begin
            if (mtimecmp_we) tstate_next = ARMED;
         end
         default: tstate_next = ARMED;
      endcase
   end

   assign irq      = (tstate_reg == FIRED);
   assign mtime    = mtime_reg;
   assign mtimecmp = mtimecmp_reg;

endmodule

// File: rtl/ysyx_22050243_clint.sv
// CLINT top: window decode, msip, read mux and one-cycle bus responses.
import ysyx_22050243_defs::*;

module ysyx_22050243_clint #(
   parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
   parameter int          TICK_DIV  = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   ysyx_22050243_clint_if.slave   bus,
   output logic                   clint_timer_irq_o,
   input  logic                   timer_irq_ready_i,
   output logic                   clint_soft_irq_o
);

   logic        in_window;
   logic        hit;
   logic        wr;
   logic        rd;
   logic [15:0] off;
   logic        sel_msip;
   logic        sel_cmp;
   logic        sel_time;
   logic        msip_reg;
   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic [63:0] rdata_next;
   logic [63:0] rdata_reg;
   logic        r_valid_reg;
   logic        w_ready_reg;

   assign in_window = (bus.data_addr_i[63:16] == BASE_ADDR[63:16]);
   assign hit       = in_window & (bus.data_r_en_i | bus.data_w_en_i);
   assign wr        = hit & bus.data_w_en_i;
   // Write wins when both enables are up, so the read is suppressed.
   assign rd        = hit & bus.data_r_en_i & ~bus.data_w_en_i;
   assign off       = {bus.data_addr_i[15:3], 3'b000};
   assign sel_msip  = (off == CLINT_MSIP_OFF);
   assign sel_cmp   = (off == CLINT_MTIMECMP_OFF);
   assign sel_time  = (off == CLINT_MTIME_OFF);

   ysyx_22050243_clint_timer #(.TICK_DIV(TICK_DIV)) u_timer (
      .clk         (clk),
      .rst         (rst),
      .mtime_we    (wr & sel_time),
      .mtimecmp_we (wr & sel_cmp),
      .wmask       (bus.data_wmask_i),
      .wdata       (bus.data_w_i),
      .irq_ready   (timer_irq_ready_i),
      .mtime       (mtime),
      .mtimecmp    (mtimecmp),
      .irq         (clint_timer_irq_o)
   );

   // msip keeps only bit 0, written through byte lane 0.
   always_ff @(posedge clk) begin
      if (rst) msip_reg <= 1'b0;
      else if (wr && sel_msip && bus.data_wmask_i[0]) msip_reg <= bus.data_w_i[0];
   end

   // Read mux over current register values; unmapped offsets read zero.
   always_comb begin
      rdata_next = 64'd0;
      if (sel_msip)      rdata_next = {63'd0, msip_reg};
      else if (sel_cmp)  rdata_next = mtimecmp;
      else if (sel_time) rdata_next = mtime;
   end

   // Bus responses one cycle after accept; read data holds between reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_reg   <= 64'd0;
         r_valid_reg <= 1'b0;
         w_ready_reg <= 1'b0;
      end else begin
         r_valid_reg <= rd;
         w_ready_reg <= wr;
         if (rd) rdata_reg <= rdata_next;
      end
   end

   assign bus.hit_o          = hit;
   assign bus.data_r_o       = rdata_reg;
   assign bus.data_r_valid_o = r_valid_reg;
   assign bus.data_w_ready_o = w_ready_reg;
   assign clint_soft_irq_o   = msip_reg;

endmodule

// File: tb/tb_ysyx_22050243_clint.sv
// Directed bench for the CLINT: register map, prescaled mtime, timer
// interrupt handshake, masked writes, window decode and reset behaviour.
module tb_ysyx_22050243_clint;
   import ysyx_22050243_defs::*;

   localparam logic [63:0] BASE     = 64'h0000_0000_0200_0000;
   localparam logic [63:0] A_MSIP   = BASE + 64'h0000;
   localparam logic [63:0] A_CMP    = BASE + 64'h4000;
   localparam logic [63:0] A_TIME   = BASE + 64'hBFF8;
   localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic irq_ready = 1'b0;
   logic timer_irq;
   logic soft_irq;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   ysyx_22050243_clint_if bus();

   ysyx_22050243_clint #(.BASE_ADDR(BASE), .TICK_DIV(2)) dut (
      .clk               (clk),
      .rst               (rst),
      .bus               (bus),
      .clint_timer_irq_o (timer_irq),
      .timer_irq_ready_i (irq_ready),
      .clint_soft_irq_o  (soft_irq)
   );

   always #5 clk = ~clk;

   // Edges since reset release; mtime model is cyc / 2 when not overwritten.
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required=<1000000", $time);
      $fatal(1, "watchdog");
   end

   task automatic idle_bus();
      bus.data_r_en_i  = 1'b0;
      bus.data_w_en_i  = 1'b0;
      bus.data_wmask_i = 8'h00;
      bus.data_addr_i  = 64'd0;
      bus.data_w_i     = 64'd0;
   endtask

   // Leaves the bench 1 time unit after the edge at which rst was sampled low... not yet: cyc==0.
   task automatic apply_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      idle_bus();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic do_read(input logic [63:0] addr, output logic [63:0] data, output logic valid);
      bus.data_r_en_i = 1'b1;
      bus.data_addr_i = addr;
      @(posedge clk); #1;
      bus.data_r_en_i = 1'b0;
      data  = bus.data_r_o;
      valid = bus.data_r_valid_o;
   endtask

   task automatic do_write(input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [7:0] mask, output logic ready);
      bus.data_w_en_i  = 1'b1;
      bus.data_addr_i  = addr;
      bus.data_w_i     = wdata;
      bus.data_wmask_i = mask;
      @(posedge clk); #1;
      bus.data_w_en_i  = 1'b0;
      ready = bus.data_w_ready_o;
   endtask

   task automatic test_reset();
      logic [63:0] d;
      logic v;
      @(posedge clk); #1;
      rst = 1'b1;
      idle_bus();
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({timer_irq, soft_irq, bus.data_r_valid_o, bus.data_w_ready_o} !== 4'b0000 || bus.data_r_o !== 64'd0) begin
         bad++;
         $display("FAIL reset_outputs: got irq=%b soft=%b rv=%b wr=%b rdata=%h required all 0",
                  timer_irq, soft_irq, bus.data_r_valid_o, bus.data_w_ready_o, bus.data_r_o);
      end
      rst = 1'b0;
      do_read(A_CMP, d, v);
      total++;
      if (v !== 1'b1 || d !== ALL_ONES) begin
         bad++;
         $display("FAIL reset_mtimecmp: got valid=%b data=%h required valid=1 data=%h", v, d, ALL_ONES);
      end
      total++;
      if (timer_irq !== 1'b0) begin
         bad++;
         $display("FAIL reset_irq: got %b required 0", timer_irq);
      end
      @(posedge clk); #1;
      total++;
      if (bus.data_r_valid_o !== 1'b0 || bus.data_r_o !== ALL_ONES) begin
         bad++;
         $display("FAIL read_pulse_hold: got valid=%b data=%h required valid=0 data=%h",
                  bus.data_r_valid_o, bus.data_r_o, ALL_ONES);
      end
      $display("test_reset done");
   endtask

   task automatic test_mtime_count();
      logic [63:0] t1, t2;
      logic v1, v2;
      apply_reset();
      repeat (19) @(posedge clk);
      #1;
      do_read(A_TIME, t1, v1);
      total++;
      if (v1 !== 1'b1 || t1 < 64'd9 || t1 > 64'd11) begin
         bad++;
         $display("FAIL mtime_20cyc: got valid=%b mtime=%0d required valid=1 mtime 9..11", v1, t1);
      end
      repeat (3) @(posedge clk);
      #1;
      do_read(A_TIME, t2, v2);
      total++;
      if (v2 !== 1'b1 || t2 !== t1 + 64'd2) begin
         bad++;
         $display("FAIL mtime_plus2: got valid=%b mtime=%0d required %0d", v2, t2, t1 + 64'd2);
      end
      $display("test_mtime_count done: t1=%0d t2=%0d", t1, t2);
   endtask

   task automatic test_timer_irq();
      logic rdy;
      logic stayed_low;
      apply_reset();
      do_write(A_CMP, 64'd16, 8'hFF, rdy);
      total++;
      if (rdy !== 1'b1) begin
         bad++;
         $display("FAIL cmp_write_ready: got %b required 1", rdy);
      end
      for (int i = 0; i < 200 && timer_irq !== 1'b1; i++) begin
         @(posedge clk); #1;
      end
      total++;
      if (timer_irq !== 1'b1 || cyc != 33) begin
         bad++;
         $display("FAIL irq_rise: got irq=%b at cycle %0d required irq=1 at cycle 33", timer_irq, cyc);
      end
      // Acknowledge: interrupt drops and must not re-fire while mtime keeps passing mtimecmp.
      irq_ready = 1'b1;
      @(posedge clk); #1;
      irq_ready = 1'b0;
      total++;
      if (timer_irq !== 1'b0) begin
         bad++;
         $display("FAIL irq_ack_fall: got %b required 0", timer_irq);
      end
      stayed_low = 1'b1;
      while (cyc < 81) begin
         @(posedge clk); #1;
         if (timer_irq !== 1'b0) stayed_low = 1'b0;
      end
      total++;
      if (stayed_low !== 1'b1) begin
         bad++;
         $display("FAIL irq_one_shot: got irq high before mtime=40, required low throughout");
      end
      // Rewriting mtimecmp re-arms; compare is still true so it fires again.
      do_write(A_CMP, 64'd16, 8'hFF, rdy);
      @(posedge clk); #1;
      total++;
      if (timer_irq !== 1'b1) begin
         bad++;
         $display("FAIL irq_rearm: got %b required 1", timer_irq);
      end
      // Write and acknowledge in the same cycle: write wins, back to ARMED.
      irq_ready = 1'b1;
      do_write(A_CMP, 64'd16, 8'hFF, rdy);
      irq_ready = 1'b0;
      total++;
      if (timer_irq !== 1'b0) begin
         bad++;
         $display("FAIL write_vs_ready: got %b required 0", timer_irq);
      end
      @(posedge clk); #1;
      total++;
      if (timer_irq !== 1'b1) begin
         bad++;
         $display("FAIL write_vs_ready_refire: got %b required 1", timer_irq);
      end
      // Served, then a single-byte mtimecmp write still re-arms.
      irq_ready = 1'b1;
      @(posedge clk); #1;
      irq_ready = 1'b0;
      do_write(A_CMP, 64'h10, 8'h01, rdy);
      @(posedge clk); #1;
      total++;
      if (timer_irq !== 1'b1) begin
         bad++;
         $display("FAIL partial_rearm: got %b required 1", timer_irq);
      end
      // While FIRED, moving mtimecmp beyond mtime withdraws the request.
      do_write(A_CMP, ALL_ONES, 8'hFF, rdy);
      @(posedge clk); #1;
      total++;
      if (timer_irq !== 1'b0) begin
         bad++;
         $display("FAIL irq_withdraw: got %b required 0", timer_irq);
      end
      $display("test_timer_irq done");
   endtask

   task automatic test_mtime_write();
      logic [63:0] d;
      logic v, rdy;
      apply_reset();
      repeat (10) @(posedge clk);
      #1;
      do_write(A_TIME, 64'h1122_3344_5566_7788, 8'h0F, rdy);
      total++;
      if (rdy !== 1'b1) begin
         bad++;
         $display("FAIL mtime_write_ready: got %b required 1", rdy);
      end
      do_read(A_TIME, d, v);
      total++;
      if (bus.data_w_ready_o !== 1'b0) begin
         bad++;
         $display("FAIL mtime_write_ready_once: got %b required 0", bus.data_w_ready_o);
      end
      total++;
      if (v !== 1'b1 || d < 64'h0000_0000_5566_7788 || d > 64'h0000_0000_5566_7789) begin
         bad++;
         $display("FAIL mtime_masked_write: got valid=%b data=%h required 0000000055667788(+1)", v, d);
      end
      $display("test_mtime_write done: mtime=%h", d);
   endtask

   task automatic test_window();
      logic [63:0] d;
      logic v;
      do_read(BASE + 64'h8000, d, v);
      total++;
      if (v !== 1'b1 || d !== 64'd0) begin
         bad++;
         $display("FAIL unmapped_read: got valid=%b data=%h required valid=1 data=0", v, d);
      end
      bus.data_addr_i = A_CMP;
      #1;
      total++;
      if (bus.hit_o !== 1'b0) begin
         bad++;
         $display("FAIL hit_no_enable: got %b required 0", bus.hit_o);
      end
      bus.data_r_en_i = 1'b1;
      #1;
      total++;
      if (bus.hit_o !== 1'b1) begin
         bad++;
         $display("FAIL hit_in_window: got %b required 1", bus.hit_o);
      end
      bus.data_addr_i = BASE + 64'h1_0000;
      #1;
      total++;
      if (bus.hit_o !== 1'b0) begin
         bad++;
         $display("FAIL hit_out_of_window: got %b required 0", bus.hit_o);
      end
      @(posedge clk); #1;
      bus.data_r_en_i = 1'b0;
      total++;
      if (bus.data_r_valid_o !== 1'b0) begin
         bad++;
         $display("FAIL out_of_window_response: got valid=%b required 0", bus.data_r_valid_o);
      end
      $display("test_window done");
   endtask

   task automatic test_rw_priority();
      logic [63:0] d;
      logic v, rdy;
      bus.data_r_en_i  = 1'b1;
      bus.data_w_en_i  = 1'b1;
      bus.data_addr_i  = A_MSIP;
      bus.data_w_i     = 64'd1;
      bus.data_wmask_i = 8'hFF;
      @(posedge clk); #1;
      idle_bus();
      total++;
      if (bus.data_w_ready_o !== 1'b1 || bus.data_r_valid_o !== 1'b0) begin
         bad++;
         $display("FAIL rw_priority: got wready=%b rvalid=%b required wready=1 rvalid=0",
                  bus.data_w_ready_o, bus.data_r_valid_o);
      end
      total++;
      if (soft_irq !== 1'b1) begin
         bad++;
         $display("FAIL soft_irq_set: got %b required 1", soft_irq);
      end
      do_write(A_MSIP, ALL_ONES, 8'hFF, rdy);
      do_read(A_MSIP, d, v);
      total++;
      if (v !== 1'b1 || d !== 64'd1) begin
         bad++;
         $display("FAIL msip_upper_bits: got valid=%b data=%h required valid=1 data=1", v, d);
      end
      do_write(A_MSIP, 64'd0, 8'hFE, rdy);
      total++;
      if (soft_irq !== 1'b1) begin
         bad++;
         $display("FAIL msip_mask_off: got %b required 1", soft_irq);
      end
      do_write(A_MSIP, 64'd0, 8'h01, rdy);
      total++;
      if (soft_irq !== 1'b0) begin
         bad++;
         $display("FAIL msip_clear: got %b required 0", soft_irq);
      end
      $display("test_rw_priority done");
   endtask

   task automatic test_back_to_back();
      logic rdy;
      do_write(A_CMP, 64'h1234_5678, 8'hFF, rdy);
      do_write(A_MSIP, 64'd1, 8'hFF, rdy);
      bus.data_r_en_i = 1'b1;
      bus.data_addr_i = A_CMP;
      @(posedge clk); #1;
      bus.data_addr_i = A_MSIP;
      total++;
      if (bus.data_r_valid_o !== 1'b1 || bus.data_r_o !== 64'h1234_5678) begin
         bad++;
         $display("FAIL b2b_first: got valid=%b data=%h required valid=1 data=12345678",
                  bus.data_r_valid_o, bus.data_r_o);
      end
      @(posedge clk); #1;
      bus.data_r_en_i = 1'b0;
      total++;
      if (bus.data_r_valid_o !== 1'b1 || bus.data_r_o !== 64'd1) begin
         bad++;
         $display("FAIL b2b_second: got valid=%b data=%h required valid=1 data=1",
                  bus.data_r_valid_o, bus.data_r_o);
      end
      @(posedge clk); #1;
      total++;
      if (bus.data_r_valid_o !== 1'b0 || bus.data_r_o !== 64'd1) begin
         bad++;
         $display("FAIL b2b_hold: got valid=%b data=%h required valid=0 data=1",
                  bus.data_r_valid_o, bus.data_r_o);
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_reset_drop();
      bus.data_r_en_i = 1'b1;
      bus.data_addr_i = A_CMP;
      rst = 1'b1;
      @(posedge clk); #1;
      bus.data_r_en_i = 1'b0;
      rst = 1'b0;
      total++;
      if (bus.data_r_valid_o !== 1'b0 || soft_irq !== 1'b0) begin
         bad++;
         $display("FAIL reset_drop: got valid=%b soft=%b required 0 0", bus.data_r_valid_o, soft_irq);
      end
      @(posedge clk); #1;
      total++;
      if (bus.data_r_valid_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_drop_late: got valid=%b required 0", bus.data_r_valid_o);
      end
      $display("test_reset_drop done");
   endtask

   initial begin
      idle_bus();
      test_reset();
      test_mtime_count();
      test_timer_irq();
      test_mtime_write();
      test_window();
      test_rw_priority();
      test_back_to_back();
      test_reset_drop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
